// File: rtl/uart_tx_framer.sv
// uart_tx_framer
// Wraps host packets into SOF, LEN, payload, CHK frames and writes them one
// byte per strobe into the UART transmitter FIFO, honouring its full flag.
//
// Ports:
//   clk          clock shared with the transmitter write port
//   reset        asynchronous, active-high reset
//   pkt_valid    packet header offered
//   pkt_len      payload length of the offered packet (1..MAX_LEN is legal)
//   pkt_ready    registered; framer can accept a header
//   pld_valid    payload byte offered
//   pld_data     payload byte
//   pld_ready    framer takes the payload byte this cycle
//   tx_full      transmitter FIFO full
//   write_data   one-cycle FIFO write strobe (never high two cycles running)
//   bus_data_in  byte written with write_data
//   busy         a frame is in progress
//   len_err      one-cycle pulse after a rejected header
//
// State table:
//   ST_IDLE | waiting for a header; pkt_ready high one cycle after entry
//   ST_SOF  | issue the start-of-frame byte
//   ST_LEN  | issue the zero-extended length, seed the checksum with it
//   ST_DATA | pass payload bytes through, rem_cnt counts down to zero
//   ST_CHK  | issue the XOR checksum, then back to idle

module uart_tx_framer #(
  parameter int                   DATA_SIZE = 8,
  parameter int                   MAX_LEN   = 16,
  parameter int                   LEN_W     = $clog2(MAX_LEN + 1),
  parameter logic [DATA_SIZE-1:0] SOF       = 8'hA5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pkt_valid,
  input  logic [LEN_W-1:0]     pkt_len,
  output logic                 pkt_ready,
  input  logic                 pld_valid,
  input  logic [DATA_SIZE-1:0] pld_data,
  output logic                 pld_ready,
  input  logic                 tx_full,
  output logic                 write_data,
  output logic [DATA_SIZE-1:0] bus_data_in,
  output logic                 busy,
  output logic                 len_err
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOF,
    ST_LEN,
    ST_DATA,
    ST_CHK
  } state_t;

  localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);

  state_t               state;
  logic [LEN_W-1:0]     len_q;
  logic [LEN_W-1:0]     rem_cnt;
  logic [DATA_SIZE-1:0] chk;
  logic                 gap;

  logic                 hdr_fire;
  logic                 len_ok;
  logic                 emit_ok;
  logic                 pld_fire;
  logic [DATA_SIZE-1:0] len_byte;

  // gap forces an idle cycle after every strobe so write_data is a clean
  // single-cycle pulse the transmitter FIFO can count one-for-one.
  assign emit_ok   = !tx_full && !gap;
  assign hdr_fire  = (state == ST_IDLE) && pkt_valid && pkt_ready;
  assign len_ok    = (pkt_len != '0) && (pkt_len <= MAX_LEN_V);
  assign pld_ready = (state == ST_DATA) && emit_ok;
  assign pld_fire  = pld_valid && pld_ready;
  assign len_byte  = DATA_SIZE'(len_q);
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      len_q       <= '0;
      rem_cnt     <= '0;
      chk         <= '0;
      gap         <= 1'b0;
      write_data  <= 1'b0;
      bus_data_in <= '0;
      pkt_ready   <= 1'b0;
      len_err     <= 1'b0;
    end else begin
      write_data <= 1'b0;
      gap        <= 1'b0;
      len_err    <= 1'b0;
      pkt_ready  <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          // Registered ready: it rises one edge after idle is entered,
          // which also lets the gap after the CHK strobe expire.
          pkt_ready <= 1'b1;
          if (hdr_fire) begin
            if (len_ok) begin
              pkt_ready <= 1'b0;
              len_q     <= pkt_len;
              rem_cnt   <= pkt_len;
              chk       <= '0;
              state     <= ST_SOF;
            end else begin
              // Bad header is consumed; ready stays up for the next one.
              len_err <= 1'b1;
            end
          end
        end

        ST_SOF: begin
          if (emit_ok) begin
            write_data  <= 1'b1;
            bus_data_in <= SOF;
            gap         <= 1'b1;
            state       <= ST_LEN;
          end
        end

        ST_LEN: begin
          if (emit_ok) begin
            write_data  <= 1'b1;
            bus_data_in <= len_byte;
            gap         <= 1'b1;
            chk         <= chk ^ len_byte;
            state       <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (pld_fire) begin
            write_data  <= 1'b1;
            bus_data_in <= pld_data;
            gap         <= 1'b1;
            chk         <= chk ^ pld_data;
            rem_cnt     <= rem_cnt - LEN_ONE;
            if (rem_cnt == LEN_ONE) begin
              state <= ST_CHK;
            end
          end
        end

        ST_CHK: begin
          if (emit_ok) begin
            write_data  <= 1'b1;
            bus_data_in <= chk;
            gap         <= 1'b1;
            state       <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
